// File: rtl/pci_arbitration_subsystem.sv
// PCI arbitration block: N burst initiators, a round-robin central arbiter and
// the wired-AND mux that forms the shared FRAME#/IRDY# pair.
module pci_arbitration_subsystem #(
   parameter int N_MASTERS   = 8,
   parameter int DATA_PHASES = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_MASTERS-1:0] start,
   output logic [N_MASTERS-1:0] req_n,
   output logic [N_MASTERS-1:0] gnt_n,
   output logic [N_MASTERS-1:0] owner,
   output logic                 global_frame_n,
   output logic                 global_irdy_n
);

   localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
   localparam int CW = (DATA_PHASES > 1) ? $clog2(DATA_PHASES) : 1;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      ADDR,
      DATA,
      LAST
   } init_state_e;

   logic [N_MASTERS-1:0] frame_n;
   logic [N_MASTERS-1:0] irdy_n;
   logic                 bus_idle;

   // Non-owners float high, so the shared line is the AND of the owners' drives.
   always_comb begin
      global_frame_n = 1'b1;
      global_irdy_n  = 1'b1;
      for (int i = 0; i < N_MASTERS; i++) begin
         if (owner[i]) begin
            global_frame_n = global_frame_n & frame_n[i];
            global_irdy_n  = global_irdy_n & irdy_n[i];
         end
      end
   end

   assign bus_idle = global_frame_n & global_irdy_n;

   for (genvar i = 0; i < N_MASTERS; i++) begin : g_init
      init_state_e   state_q;
      logic          req_q;
      logic          frame_q;
      logic          irdy_q;
      logic          owner_q;
      logic [CW-1:0] phase_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q   <= IDLE;
            req_q     <= 1'b1;
            frame_q   <= 1'b1;
            irdy_q    <= 1'b1;
            owner_q   <= 1'b0;
            phase_cnt <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start[i]) begin
                     state_q <= REQ;
                     req_q   <= 1'b0;
                  end
               end
               REQ: begin
                  if (!gnt_n[i] && bus_idle) begin
                     state_q <= ADDR;
                     req_q   <= 1'b1;
                     frame_q <= 1'b0;
                     irdy_q  <= 1'b1;
                     owner_q <= 1'b1;
                  end
               end
               ADDR: begin
                  irdy_q <= 1'b0;
                  if (DATA_PHASES == 1) begin
                     state_q <= LAST;
                     frame_q <= 1'b1;
                  end else begin
                     state_q   <= DATA;
                     phase_cnt <= CW'(1);
                  end
               end
               DATA: begin
                  if (phase_cnt == CW'(DATA_PHASES - 1)) begin
                     state_q <= LAST;
                     frame_q <= 1'b1;
                  end else begin
                     phase_cnt <= phase_cnt + CW'(1);
                  end
               end
               LAST: begin
                  state_q <= IDLE;
                  irdy_q  <= 1'b1;
                  owner_q <= 1'b0;
               end
               default: begin
                  state_q <= IDLE;
                  req_q   <= 1'b1;
                  frame_q <= 1'b1;
                  irdy_q  <= 1'b1;
                  owner_q <= 1'b0;
               end
            endcase
         end
      end

      assign req_n[i]   = req_q;
      assign frame_n[i] = frame_q;
      assign irdy_n[i]  = irdy_q;
      assign owner[i]   = owner_q;
   end

   logic [IW-1:0] last_ptr;
   logic [IW-1:0] pick;
   logic          found;
   int            scan_idx;

   always_comb begin
      found    = 1'b0;
      pick     = '0;
      scan_idx = 0;
      for (int k = 0; k < N_MASTERS; k++) begin
         scan_idx = (int'(last_ptr) + 1 + k) % N_MASTERS;
         if (!found && !req_n[scan_idx]) begin
            found = 1'b1;
            pick  = IW'(scan_idx);
         end
      end
   end

   // last_ptr always names the live grantee while any GNT# is low, so it doubles as the hold index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_n    <= '1;
         last_ptr <= IW'(N_MASTERS - 1);
      end else if (!(&gnt_n) && !req_n[last_ptr]) begin
         gnt_n <= gnt_n;
      end else if (found) begin
         gnt_n    <= ~(N_MASTERS'(1) << pick);
         last_ptr <= pick;
      end else begin
         gnt_n <= '1;
      end
   end

endmodule

// File: tb/tb_pci_arbitration_subsystem.sv
// Bench for pci_arbitration_subsystem: randomized start patterns checked every
// cycle against a transaction-position reference model.
module tb_pci_arbitration_subsystem;

   localparam int N  = 8;
   localparam int DP = 3;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] start;
   logic [N-1:0] req_n;
   logic [N-1:0] gnt_n;
   logic [N-1:0] owner;
   logic         global_frame_n;
   logic         global_irdy_n;

   int n_compared;
   int n_mismatched;

   pci_arbitration_subsystem #(.N_MASTERS(N), .DATA_PHASES(DP)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .req_n          (req_n),
      .gnt_n          (gnt_n),
      .owner          (owner),
      .global_frame_n (global_frame_n),
      .global_irdy_n  (global_irdy_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: m_pos is the cycle offset inside a burst (-1 = not on the bus).
   bit m_req [N];
   int m_pos [N];
   int m_grant;
   int m_last;

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_req[i] = 1'b0;
         m_pos[i] = -1;
      end
      m_grant = -1;
      m_last  = N - 1;
   endtask

   task automatic model_step();
      bit cur_req [N];
      bit idle;
      idle = 1'b1;
      for (int i = 0; i < N; i++) begin
         cur_req[i] = m_req[i];
         if (m_pos[i] >= 0) idle = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
         if (m_pos[i] >= 0) begin
            m_pos[i] = (m_pos[i] == DP) ? -1 : m_pos[i] + 1;
         end else if (cur_req[i]) begin
            if (m_grant == i && idle) begin
               m_pos[i] = 0;
               m_req[i] = 1'b0;
            end
         end else if (start[i]) begin
            m_req[i] = 1'b1;
         end
      end
      if (!(m_grant >= 0 && cur_req[m_grant])) begin
         m_grant = -1;
         for (int k = 0; k < N; k++) begin
            if (m_grant < 0 && cur_req[(m_last + 1 + k) % N]) m_grant = (m_last + 1 + k) % N;
         end
         if (m_grant >= 0) m_last = m_grant;
      end
   endtask

   task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
      end
   endtask

   task automatic check_all();
      logic [N-1:0] e_req, e_gnt, e_own;
      logic         e_frame, e_irdy;
      e_frame = 1'b1;
      e_irdy  = 1'b1;
      for (int i = 0; i < N; i++) begin
         e_req[i] = ~m_req[i];
         e_gnt[i] = (m_grant != i);
         e_own[i] = (m_pos[i] >= 0);
         if (m_pos[i] >= 0 && m_pos[i] < DP) e_frame = 1'b0;
         if (m_pos[i] >= 1) e_irdy = 1'b0;
      end
      check_output("req_n", 32'(req_n), 32'(e_req));
      check_output("gnt_n", 32'(gnt_n), 32'(e_gnt));
      check_output("owner", 32'(owner), 32'(e_own));
      check_output("frame_n", 32'(global_frame_n), 32'(e_frame));
      check_output("irdy_n", 32'(global_irdy_n), 32'(e_irdy));
      check_output("gnt_at_most_one", 32'($countones(~gnt_n) <= 1), 32'd1);
      check_output("owner_at_most_one", 32'($countones(owner) <= 1), 32'd1);
   endtask

   task automatic apply_stimulus(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk);
         if (rst_n) model_step();
         @(negedge clk);
         check_all();
      end
   endtask

   initial begin
      bit in_data;
      int budget;
      n_compared   = 0;
      n_mismatched = 0;
      model_reset();
      rst_n = 1'b0;
      start = 8'hFF;
      apply_stimulus(3);
      check_output("reset_req_n", 32'(req_n), 32'hFF);
      check_output("reset_gnt_n", 32'(gnt_n), 32'hFF);

      start = 8'h01;
      rst_n = 1'b1;
      apply_stimulus(20);

      start = 8'h00;
      apply_stimulus(10);
      for (int i = 0; i < 4; i++) begin
         start[i] = 1'b1;
         apply_stimulus(2);
      end
      apply_stimulus(40);

      start[3] = 1'b0;
      start[1] = 1'b0;
      start[0] = 1'b0;
      start[5] = 1'b1;
      start[7] = 1'b1;
      apply_stimulus(50);

      for (int c = 0; c < 300; c++) begin
         if ($urandom_range(0, 5) == 0) start[$urandom_range(0, N - 1)] ^= 1'b1;
         apply_stimulus(1);
      end

      start = 8'h00;
      apply_stimulus(40);
      check_output("drain_gnt_n", 32'(gnt_n), 32'hFF);
      check_output("drain_req_n", 32'(req_n), 32'hFF);
      check_output("drain_bus_idle", 32'({global_frame_n, global_irdy_n}), 32'h3);

      start   = 8'hFF;
      in_data = 1'b0;
      budget  = 0;
      while (!in_data && budget < 100) begin
         apply_stimulus(1);
         budget++;
         for (int i = 0; i < N; i++) if (m_pos[i] == 1) in_data = 1'b1;
      end
      check_output("reach_data_phase", 32'(in_data), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      apply_stimulus(2);
      rst_n = 1'b1;
      budget = 0;
      while (gnt_n == 8'hFF && budget < 10) begin
         apply_stimulus(1);
         budget++;
      end
      check_output("first_grant_after_reset", 32'(gnt_n), 32'hFE);
      apply_stimulus(30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
